// File: rtl/divider_array_scheduler.sv
// Round-robin scheduler in front of one shared combinational 16/8 array divider.
// Holds operands for SETTLE cycles, samples q/r and returns a tagged response; dz/ovf bypass the divider.
module divider_array_scheduler #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_n,
  input  logic [8*NREQ-1:0]    req_d,
  output logic [15:0]          div_n,
  output logic [7:0]           div_d,
  input  logic [7:0]           div_q,
  input  logic [7:0]           div_r,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_q,
  output logic [7:0]           rsp_r,
  output logic                 rsp_dz,
  output logic                 rsp_ovf
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant;
  logic            grant_vld;
  logic [CW-1:0]   cnt;
  logic [15:0]     n_arr [NREQ];
  logic [7:0]      d_arr [NREQ];
  logic [15:0]     sel_n;
  logic [7:0]      sel_d;
  logic            sel_dz;
  logic            sel_ovf;
  logic            accept;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign n_arr[i] = req_n[16*i+15:16*i];
    assign d_arr[i] = req_d[8*i+7:8*i];
  end

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int s;
    logic [IDW-1:0] idx;
    s         = 0;
    idx       = '0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      idx = IDW'(s);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  assign sel_n     = n_arr[grant];
  assign sel_d     = d_arr[grant];
  assign sel_dz    = (sel_d == 8'd0);
  assign sel_ovf   = !sel_dz && (sel_n[15:8] >= sel_d);
  assign accept    = rst_n && (state == S_IDLE) && grant_vld;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (sel_dz || sel_ovf) ? S_RESP : S_SETTLE;
      S_SETTLE: if (cnt == '0) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand and response registers; div_n/div_d only change on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      cnt     <= '0;
      div_n   <= '0;
      div_d   <= '0;
      rsp_id  <= '0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_dz  <= 1'b0;
      rsp_ovf <= 1'b0;
    end else begin
      if (accept) begin
        div_n   <= sel_n;
        div_d   <= sel_d;
        rsp_id  <= grant;
        rsp_dz  <= sel_dz;
        rsp_ovf <= sel_ovf;
        if (sel_dz || sel_ovf) begin
          rsp_q <= 8'hFF;
          rsp_r <= sel_n[7:0];
        end else begin
          cnt <= CW'(SETTLE - 1);
        end
      end
      if (state == S_SETTLE) begin
        if (cnt == '0) begin
          rsp_q   <= div_q;
          rsp_r   <= div_r;
          rsp_dz  <= 1'b0;
          rsp_ovf <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if ((state == S_RESP) && rsp_ready)
        ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    end
  end

endmodule
